// File: rtl/dda_pkg.sv
// Shared constants and state encoding for the DDA host link
// (UART frame exchange with the posit DDA core).
package dda_pkg;

    localparam int DDA_N          = 16;
    localparam int DDA_CFG_BYTES  = 10;
    localparam int DDA_RESP_BYTES = 5;

    // Field LSB offsets inside cfg = {ic1, ic2, vK_M, vD_M, dt}
    localparam int DDA_NUM_FIELDS = 5;
    localparam int IC1_OFS        = 4 * DDA_N;
    localparam int IC2_OFS        = 3 * DDA_N;
    localparam int VKM_OFS        = 2 * DDA_N;
    localparam int VDM_OFS        = 1 * DDA_N;
    localparam int DT_OFS         = 0;

    localparam int CNT_W = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_WAIT_ACK,
        S_WAIT_IDLE,
        S_RECV,
        S_FINISH
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/dda_host_link.sv
// Host side of the DDA UART link: ships one cfg frame MSB-first, then collects {v1, v2}.
// Optional response watchdog enabled by defining DDA_HOST_TIMEOUT_EN.
module dda_host_link
    import dda_pkg::*;
#(
    parameter int N              = DDA_N,
    parameter int CFG_BYTES      = DDA_CFG_BYTES,
    parameter int RESP_BYTES     = DDA_RESP_BYTES,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_start,
    input  logic [5*N-1:0] i_cfg,
    output logic           o_tx_start,
    output logic [7:0]     o_tx_byte,
    input  logic           i_tx_busy,
    input  logic           i_rx_valid,
    input  logic [7:0]     i_rx_byte,
    input  logic           i_rx_err,
    output logic           o_busy,
    output logic           o_done,
    output logic           o_err,
    output logic [N-1:0]   o_v1,
    output logic [N-1:0]   o_v2
);

    localparam logic [CNT_W-1:0] LAST_TX = CNT_W'(CFG_BYTES);
    localparam logic [CNT_W-1:0] LAST_RX = CNT_W'(RESP_BYTES - 1);
    localparam logic [CNT_W-1:0] V_BYTES = CNT_W'((2 * N) / 8);

    state_t           r_state, w_next;
    logic [5*N-1:0]   r_tx_shift;
    logic [2*N-1:0]   r_rx_shift;
    logic [CNT_W-1:0] r_tx_cnt, r_rx_cnt;
    logic             r_tx_start, r_busy, r_done, r_err;
    logic [7:0]       r_tx_byte;
    logic [N-1:0]     r_v1, r_v2;
    logic             w_accept, w_fire, w_rx_take, w_rx_fail, w_finish, w_to_hit;

`ifdef DDA_HOST_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] r_to_cnt;

    // Held at zero outside RECV, so it starts from zero on entry; each byte re-arms it.
    always_ff @(posedge i_clk) begin
        if (i_rst_n)                                r_to_cnt <= '0;
        else if (r_state != S_RECV || i_rx_valid)   r_to_cnt <= '0;
        else                                        r_to_cnt <= r_to_cnt + 1'b1;
    end

    assign w_to_hit = (r_state == S_RECV) && (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
    // Watchdog compiled out; RECV waits for the responder indefinitely.
    assign w_to_hit = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst_n) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_fire    = 1'b0;
        w_rx_take = 1'b0;
        w_rx_fail = 1'b0;
        w_finish  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start && !r_busy) begin
                    w_accept = 1'b1;
                    w_next   = S_LOAD;
                end
            end
            S_LOAD: w_next = S_SEND;
            S_SEND: begin
                if (!i_tx_busy) begin
                    w_fire = 1'b1;
                    w_next = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                if (i_tx_busy) w_next = S_WAIT_IDLE;
            end
            S_WAIT_IDLE: begin
                if (!i_tx_busy) w_next = (r_tx_cnt >= LAST_TX) ? S_RECV : S_SEND;
            end
            S_RECV: begin
                // A receive error outranks a byte arriving in the same cycle.
                if (i_rx_err || w_to_hit) begin
                    w_rx_fail = 1'b1;
                    w_next    = S_IDLE;
                end else if (i_rx_valid) begin
                    w_rx_take = 1'b1;
                    if (r_rx_cnt == LAST_RX) w_next = S_FINISH;
                end
            end
            S_FINISH: begin
                w_finish = 1'b1;
                w_next   = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst_n) begin
            r_tx_shift <= '0;
            r_rx_shift <= '0;
            r_tx_cnt   <= '0;
            r_rx_cnt   <= '0;
            r_tx_start <= 1'b0;
            r_tx_byte  <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_v1       <= '0;
            r_v2       <= '0;
        end else begin
            r_tx_start <= w_fire;
            r_done     <= w_finish;
            if (w_accept) begin
                r_tx_shift <= i_cfg;
                r_err      <= 1'b0;
                r_busy     <= 1'b1;
            end
            if (r_state == S_LOAD) begin
                r_tx_cnt   <= '0;
                r_rx_cnt   <= '0;
                r_rx_shift <= '0;
            end
            // tx_byte only changes on a fire, so it holds across the whole UART transfer.
            if (w_fire) begin
                r_tx_byte  <= r_tx_shift[5*N-1 -: 8];
                r_tx_shift <= {r_tx_shift[5*N-9:0], 8'h00};
                r_tx_cnt   <= sat_inc(r_tx_cnt);
            end
            if (w_rx_take) begin
                r_rx_cnt <= sat_inc(r_rx_cnt);
                if (r_rx_cnt < V_BYTES) r_rx_shift <= {r_rx_shift[2*N-9:0], i_rx_byte};
            end
            if (w_finish) begin
                r_v1   <= r_rx_shift[2*N-1:N];
                r_v2   <= r_rx_shift[N-1:0];
                r_busy <= 1'b0;
            end
            if (w_rx_fail) begin
                r_err  <= 1'b1;
                r_busy <= 1'b0;
            end
        end
    end

    assign o_tx_start = r_tx_start;
    assign o_tx_byte  = r_tx_byte;
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_err      = r_err;
    assign o_v1       = r_v1;
    assign o_v2       = r_v2;

endmodule

// File: tb/tb_dda_host_link.sv
// Directed bench for dda_host_link: UART tx model plus a scripted DDA responder.
module tb_dda_host_link;

    localparam int N = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [5*N-1:0] cfg = '0;
    logic           tx_start, tx_busy;
    logic [7:0]     tx_byte;
    logic           rx_valid = 1'b0;
    logic [7:0]     rx_byte = 8'h00;
    logic           rx_err = 1'b0;
    logic           busy, done, err;
    logic [N-1:0]   v1, v2;

    int n_cmp = 0, n_bad = 0;
    int uart_cnt = 0, n_done = 0, n_bad_start = 0, n_hold = 0;
    logic [7:0] tx_log[$];

    always #5 clk = ~clk;

    dda_host_link #(.N(N), .CFG_BYTES(10), .RESP_BYTES(5), .TIMEOUT_CYCLES(100)) dut (
        .i_clk(clk), .i_rst_n(rst), .i_start(start), .i_cfg(cfg),
        .o_tx_start(tx_start), .o_tx_byte(tx_byte), .i_tx_busy(tx_busy),
        .i_rx_valid(rx_valid), .i_rx_byte(rx_byte), .i_rx_err(rx_err),
        .o_busy(busy), .o_done(done), .o_err(err), .o_v1(v1), .o_v2(v2)
    );

    // UART tx model: busy for 6 cycles after each tx_start.
    assign tx_busy = (uart_cnt != 0);

    always @(posedge clk) begin
        if (done) n_done <= n_done + 1;
        if (tx_start) begin
            if (tx_busy) n_bad_start <= n_bad_start + 1;
            tx_log.push_back(tx_byte);
            uart_cnt <= 6;
        end else if (uart_cnt != 0) begin
            if (tx_log.size() > 0 && tx_byte != tx_log[$]) n_hold <= n_hold + 1;
            uart_cnt <= uart_cnt - 1;
        end
    end

    task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic go(input logic [79:0] c);
        cfg = c; start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_n(input int tgt);
        int k = 0;
        while (tx_log.size() < tgt && k < 3000) begin tick(1); k++; end
        chk("tx_count_reached", tx_log.size(), tgt);
    endtask

    // Returns at the first negedge where all bytes are out and the UART is idle.
    task automatic wait_tx(input int tgt);
        int k = 0;
        while ((tx_log.size() < tgt || tx_busy) && k < 3000) begin tick(1); k++; end
        chk("tx_frame_done", tx_log.size(), tgt);
    endtask

    task automatic resp(input logic [39:0] b, input int err_at);
        tick(2);
        for (int i = 0; i < 5; i++) begin
            rx_byte = b[39-8*i -: 8]; rx_valid = 1'b1; rx_err = (i == err_at);
            tick(1);
            rx_valid = 1'b0; rx_err = 1'b0;
            if (i == err_at) break;
            tick(3);
        end
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (busy && k < 500) begin tick(1); k++; end
        chk(tag, busy, 0);
        tick(2);
    endtask

    task automatic chk_rst(input string tag);
        chk({tag, "_tx_start"}, tx_start, 0);
        chk({tag, "_tx_byte"}, tx_byte, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_v1"}, v1, 0);
        chk({tag, "_v2"}, v2, 0);
    endtask

    task automatic chk_bytes(input string tag, input int base, input logic [79:0] c);
        logic [79:0] cc;
        cc = c;
        chk({tag, "_nbytes"}, tx_log.size() - base, 10);
        for (int i = 0; i < 10 && base + i < tx_log.size(); i++)
            chk($sformatf("%s_b%0d", tag, i), tx_log[base+i], cc[79-8*i -: 8]);
    endtask

    initial begin
        int base, d0, s0, h0, n;

        // reset state
        tick(3);
        chk_rst("rst");
        rst = 1'b0;
        tick(2);

        // basic frame + response decode; a stray rx_valid while sending is ignored
        base = tx_log.size(); d0 = n_done; s0 = n_bad_start; h0 = n_hold;
        go(80'h0102_0304_0506_0708_090A);
        chk("basic_busy_on", busy, 1);
        rx_byte = 8'h77; rx_valid = 1'b1; tick(1); rx_valid = 1'b0;
        wait_tx(base + 10);
        resp(40'hAB_CD_12_34_FF, -1);
        wait_idle("basic_idle");
        chk_bytes("basic", base, 80'h0102_0304_0506_0708_090A);
        chk("basic_start_while_busy", n_bad_start - s0, 0);
        chk("basic_byte_hold", n_hold - h0, 0);
        chk("basic_v1", v1, 16'hABCD);
        chk("basic_v2", v2, 16'h1234);
        chk("basic_done_cnt", n_done - d0, 1);
        chk("basic_err", err, 0);

        // start while busy: second start during byte 3 must not re-latch cfg
        base = tx_log.size(); d0 = n_done;
        go(80'h1122_3344_5566_7788_99AA);
        wait_n(base + 3);
        go(80'hFFEE_DDCC_BBAA_9988_7766);
        wait_tx(base + 10);
        resp(40'h55_66_77_88_99, -1);
        wait_idle("sbusy_idle");
        tick(20);
        chk_bytes("sbusy", base, 80'h1122_3344_5566_7788_99AA);
        chk("sbusy_v1", v1, 16'h5566);
        chk("sbusy_v2", v2, 16'h7788);
        chk("sbusy_done_cnt", n_done - d0, 1);

        // rx error on 2nd byte (together with rx_valid): err set, no done, v held
        base = tx_log.size(); d0 = n_done;
        go(80'h0);
        wait_tx(base + 10);
        resp(40'hDE_AD_BE_EF_00, 1);
        wait_idle("rxerr_idle");
        chk("rxerr_err", err, 1);
        chk("rxerr_done_cnt", n_done - d0, 0);
        chk("rxerr_v1", v1, 16'h5566);
        chk("rxerr_v2", v2, 16'h7788);
        rx_byte = 8'h42; rx_valid = 1'b1; tick(1); rx_valid = 1'b0; tick(5);
        chk("rxerr_err_sticky", err, 1);
        chk("rxerr_v1_idle_rx", v1, 16'h5566);

        // mid-frame reset during 5th byte; the start also clears err
        base = tx_log.size();
        go(80'h0102_0304_0506_0708_090A);
        chk("mid_err_cleared", err, 0);
        wait_n(base + 5);
        rst = 1'b1;
        tick(1);
        chk_rst("mid_rst");
        rst = 1'b0;
        tick(60);
        chk("mid_no_more_tx", tx_log.size(), base + 5);
        chk("mid_busy_after", busy, 0);

        // watchdog: silent responder
        base = tx_log.size(); d0 = n_done;
        go(80'h0A09_0807_0605_0403_0201);
        wait_tx(base + 10);
`ifdef DDA_HOST_TIMEOUT_EN
        n = 0;
        while (!err && n < 400) begin tick(1); n++; end
        chk("to_cycles", n, 101);
        chk("to_err", err, 1);
        chk("to_busy", busy, 0);
        chk("to_done_cnt", n_done - d0, 0);
`else
        n = 0;
        tick(300);
        chk("nto_busy_held", busy, 1);
        chk("nto_err", err, 0);
        chk("nto_done_cnt", n_done - d0, n);
        rst = 1'b1; tick(1); rst = 1'b0; tick(2);
        chk("nto_busy_reset", busy, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dda_host_link.md
DDA_HOST_LINK -- requirements
Module: dda_host_link

Interface
REQ-001 Parameter N, default 16, posit word width of each DDA field.
REQ-002 Parameter CFG_BYTES, default 10, bytes per configuration frame (5 fields x N/8).
REQ-003 Parameter RESP_BYTES, default 5, bytes returned by the DDA per frame; minimum 4.
REQ-004 Parameter TIMEOUT_CYCLES, default 50000, response watchdog limit in clk cycles.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst_n  in  1  synchronous, active-high reset (asserted high resets the block, despite the name).
REQ-007 start  in  1  one-cycle request to run one frame exchange; ignored unless idle.
REQ-008 cfg  in  5*N  {ic1, ic2, vK_M, vD_M, dt}, ic1 in the MSBs; sampled on an accepted start.
REQ-009 tx_start  out  1  one-cycle pulse to the UART core: send tx_byte.
REQ-010 tx_byte  out  8  byte to transmit.
REQ-011 tx_busy  in  1  UART is_transmitting.
REQ-012 rx_valid  in  1  UART received pulse.
REQ-013 rx_byte  in  8  UART received byte.
REQ-014 rx_err  in  1  UART recv_error pulse.
REQ-015 busy  out  1  high from the accepted start until done or error.
REQ-016 done  out  1  one-cycle pulse when v1/v2 are updated.
REQ-017 err  out  1  sticky; set on rx_err or timeout; cleared by the next accepted start.
REQ-018 v1, v2  out  N each  last received state words.

Function
REQ-019 States: IDLE, LOAD, SEND, WAIT_ACK, WAIT_IDLE, RECV, FINISH.
REQ-020 IDLE: start is accepted only when busy=0; accepting it latches cfg into a shift register, clears err, and moves to LOAD.
REQ-021 Bytes go out MSB-first: byte 0 is cfg[5N-1:5N-8], and byte CFG_BYTES-1 is the LSB byte of dt.
REQ-022 SEND: when tx_busy=0, pulse tx_start for exactly one cycle and drive tx_byte, then go to WAIT_ACK.
REQ-023 WAIT_ACK waits for tx_busy=1. WAIT_IDLE waits for tx_busy=0, then either returns to SEND or, after the last byte, goes to RECV.
REQ-024 tx_byte holds its value from the tx_start cycle until tx_busy falls.
REQ-025 rx_valid is ignored in every state other than RECV.
REQ-026 RECV: each rx_valid shifts in one byte, MSB-first; bytes 0-3 form {v1, v2}, and bytes 4..RESP_BYTES-1 are counted and discarded.
REQ-027 After RESP_BYTES bytes, go to FINISH: load v1/v2 and pulse done for one cycle, then return to IDLE.
REQ-028 rx_err in RECV sets err, leaves v1/v2 unchanged, emits no done, and returns to IDLE.
REQ-029 A start pulse while busy=1 has no effect.
REQ-030 When rx_valid and rx_err occur in the same cycle, rx_err wins and the byte is dropped.
REQ-031 Byte counters are 4 bits wide and saturate; they never wrap within a frame.

Reset
REQ-032 While rst_n=1 at a clock edge: state=IDLE, all counters=0, tx_start=0, tx_byte=0, busy=0, done=0, err=0, v1=v2=0.
REQ-033 Reset mid-frame aborts immediately. No further tx_start is issued, and a partially received response is discarded.

Configuration
REQ-034 Macro DDA_HOST_TIMEOUT_EN defined: a counter clears on entry to RECV and on each rx_valid.
REQ-035 With the macro defined, reaching TIMEOUT_CYCLES sets err and returns the block to IDLE with no done pulse.
REQ-036 Macro undefined: no counter exists and RECV waits indefinitely.

Structure
REQ-037 Shared package dda_pkg holds: N, CFG_BYTES, RESP_BYTES, the field order/offset constants, and the state enum typedef.
REQ-038 No sub-module is required. The uart core is instantiated by the parent with BAUD_RATE 9600 and CLK_FREQ 5000000.

Verification
REQ-039 Basic frame: cfg=80'h0102_0304_0506_0708_090A, with a UART model looped to a DDA responder model. Required: tx_byte sequence 01,02,...,0A; ten tx_start pulses, each issued only while tx_busy=0.
REQ-040 Response decode: responder returns AB,CD,12,34,FF. Required: v1=16'hABCD, v2=16'h1234, one done pulse, err=0.
REQ-041 Start while busy: pulse start during the 3rd byte. Required: exactly 10 bytes sent, and cfg is not re-latched.
REQ-042 Receive error: assert rx_err on the 2nd response byte. Required: err=1, no done, v1/v2 hold their prior values, block returns to IDLE.
REQ-043 Timeout (macro defined, TIMEOUT_CYCLES=100): responder stays silent. Required: err=1 exactly 100 cycles after RECV entry. With the macro undefined, busy stays high.
REQ-044 Mid-frame reset: assert rst_n for 1 cycle during the 5th tx byte. Required: all outputs take their reset values next cycle, and no further tx_start is issued.
